// File: rtl/video_timing_recovery.sv
// Rebuilds h/v coordinates, new_frame and lock status from an incoming DE/HSYNC/VSYNC stream.
// Optional build macro HSYNC_CHECK_EN adds hsync placement checking against the recovered column.
module video_timing_recovery #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int H_FRONT_PORCH   = 110,
    parameter int H_SYNC_WIDTH    = 40,
    parameter int H_BACK_PORCH    = 220,
    parameter int ACTIVE_LINES    = 720,
    parameter int V_FRONT_PORCH   = 5,
    parameter int V_SYNC_WIDTH    = 5,
    parameter int V_BACK_PORCH    = 20,
    parameter int LOCK_FRAMES     = 2,
    localparam int TOTAL_PIXELS   = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
    localparam int TOTAL_LINES    = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
    localparam int HW             = $clog2(TOTAL_PIXELS),
    localparam int VW             = $clog2(TOTAL_LINES)
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic [HW-1:0] h_count,
    output logic [VW-1:0] v_count,
    output logic          active_draw,
    output logic          new_frame,
    output logic          locked,
    output logic          timing_error,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECKING = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam int CW = $clog2(LOCK_FRAMES + 1);

    localparam logic [HW-1:0] H_LAST       = HW'(TOTAL_PIXELS - 1);
    localparam logic [HW-1:0] H_ACT_LAST   = HW'(ACTIVE_H_PIXELS - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(ACTIVE_H_PIXELS);
    localparam logic [VW-1:0] V_LAST       = VW'(TOTAL_LINES - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(ACTIVE_LINES);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(ACTIVE_LINES - 1);
    localparam logic [CW-1:0] CNT_LOCK     = CW'(LOCK_FRAMES);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d, v_inc;
    logic          de_q, vs_q;
    logic          armed_q, armed_d;
    logic          te_q, locked_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    logic de_rise, de_fall, vs_rise, h_last, frame_start;
    logic viol_a, viol_b, viol_c, viol_d, viol_e, violation;

    always_comb begin
        de_rise     = de_in & ~de_q;
        de_fall     = ~de_in & de_q;
        vs_rise     = vsync_in & ~vs_q;
        h_last      = (h_q == H_LAST);
        v_inc       = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        // A vsync edge coinciding with the DE edge arms and starts the frame at once.
        frame_start = de_rise & (armed_q | vs_rise);

        h_d = h_q + HW'(1);
        v_d = v_q;
        if (de_rise || h_last) begin
            h_d = '0;
            v_d = v_inc;
        end
        if (frame_start) begin
            v_d = '0;
        end

        armed_d = armed_q;
        if (frame_start) begin
            armed_d = 1'b0;
        end else if (vs_rise) begin
            armed_d = 1'b1;
        end
    end

`ifdef HSYNC_CHECK_EN
    localparam logic [HW-1:0] H_SYNC_START = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    logic hs_q;

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            hs_q <= 1'b0;
        end else begin
            hs_q <= hsync_in;
        end
    end

    always_comb begin
        viol_e = (hsync_in & ~hs_q) ? (h_d != H_SYNC_START) : (h_d == H_SYNC_START);
    end
`else
    logic unused_hsync;
    assign unused_hsync = hsync_in;
    assign viol_e       = 1'b0;
`endif

    always_comb begin
        viol_a    = de_rise & ~h_last;
        viol_b    = de_fall & (h_q != H_ACT_LAST);
        viol_c    = frame_start & (v_q != V_LAST);
        viol_d    = de_rise & ~frame_start & (v_inc >= V_ACT);
        violation = (state_q != ST_UNLOCKED) & (viol_a | viol_b | viol_c | viol_d | viol_e);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CW'(1);
        case (state_q)
            ST_UNLOCKED: begin
                if (frame_start) begin
                    state_d = ST_CHECKING;
                    cnt_d   = '0;
                end
            end
            ST_CHECKING: begin
                if (violation) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end else if (frame_start) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LOCK) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (violation) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= '0;
            de_q     <= 1'b0;
            vs_q     <= 1'b0;
            armed_q  <= 1'b0;
            te_q     <= 1'b0;
            locked_q <= 1'b0;
            state_q  <= ST_UNLOCKED;
            cnt_q    <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            de_q     <= de_in;
            vs_q     <= vsync_in;
            armed_q  <= armed_d;
            te_q     <= violation;
            locked_q <= (state_d == ST_LOCKED);
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign h_count      = h_q;
    assign v_count      = v_q;
    assign active_draw  = de_q;
    assign timing_error = te_q;
    assign locked       = locked_q;
    assign dbg_state    = state_q;
    assign new_frame    = locked_q & (h_q == H_ACT_END) & (v_q == V_ACT_LAST);

endmodule

// File: doc/video_timing_recovery.md
Name: video_timing_recovery

Overview:
- Receive side of the raster timing interface: takes an incoming DE/HSYNC/VSYNC pixel stream and rebuilds the pixel coordinates (h_count, v_count), active_draw and new_frame from it.
- Checks the incoming geometry against the parameterised timing.
- Reports lock and timing errors.
- Sits at the front of the video capture/loopback path, so downstream pixel consumers see the same coordinate interface the timing generator produces.

Parameters:
ACTIVE_H_PIXELS, 1280, active pixels per line
H_FRONT_PORCH, 110, pixels from end of active to hsync start
H_SYNC_WIDTH, 40, hsync width in pixels
H_BACK_PORCH, 220, pixels from hsync end to next active
ACTIVE_LINES, 720, active lines per frame
V_FRONT_PORCH, 5, lines
V_SYNC_WIDTH, 5, lines
V_BACK_PORCH, 20, lines
LOCK_FRAMES, 2, consecutive clean frames required to assert locked (>=1)
Derived: TOTAL_PIXELS = sum of H params; TOTAL_LINES = sum of V params.

Ports:
pixel_clk  input  1  pixel clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
de_in  input  1  incoming data enable (active draw)
hsync_in  input  1  incoming hsync, active high
vsync_in  input  1  incoming vsync, active high
h_count  output  $clog2(TOTAL_PIXELS)  recovered column of the sample in active_draw
v_count  output  $clog2(TOTAL_LINES)  recovered line
active_draw  output  1  registered de_in
new_frame  output  1  single-cycle pulse
locked  output  1  timing verified
timing_error  output  1  single-cycle pulse per detected violation

Behaviour:
- Reset is asynchronous and active-high. All state clears immediately: h_count=0, v_count=0, active_draw=0, locked=0, timing_error=0, frame_armed=0, FSM=UNLOCKED, clean-frame count=0. new_frame=0 follows.
- Latency is 1 cycle. The outputs after edge n describe the input sample taken at edge n. active_draw = de_in delayed by one register.
- Edge detects use the registered copies: de_rise = de_in & ~active_draw; de_fall = ~de_in & active_draw; vs_rise = vsync_in & ~vs_q; hs_rise likewise.
- next_h / next_v:
  - Default: next_h = h_count+1, wrapping from TOTAL_PIXELS-1 to 0. On wrap, next_v = v_count+1, wrapping from TOTAL_LINES-1 to 0.
  - On de_rise, next_h = 0. If h_count was not TOTAL_PIXELS-1, v_count still increments (forced new line).
  - frame_armed is set on vs_rise. On de_rise while frame_armed: next_v = 0 and frame_armed clears. This is a "frame start".
  - vs_rise and de_rise in the same cycle: the arm takes effect first, so that cycle is itself a frame start.
- Checks: each raises a violation, evaluated only when FSM != UNLOCKED.
  - (a) de_rise with h_count != TOTAL_PIXELS-1.
  - (b) de_fall with h_count != ACTIVE_H_PIXELS-1.
  - (c) Frame start with v_count != TOTAL_LINES-1.
  - (d) de_rise on a non-frame-start line where next_v >= ACTIVE_LINES.
- On a violation, timing_error pulses 1 on the following cycle. Multiple violations in one cycle produce one pulse.
- FSM:
  - UNLOCKED: on frame start -> CHECKING, count=0.
  - CHECKING: each frame start with no violation since the previous frame start increments count. When count reaches LOCK_FRAMES -> LOCKED. A violation -> UNLOCKED.
  - LOCKED: a violation -> UNLOCKED. locked=0 on the same edge timing_error asserts.
  - locked is high iff FSM==LOCKED, registered.
- new_frame = locked & (h_count==ACTIVE_H_PIXELS) & (v_count==ACTIVE_LINES-1). It is decoded from the registered counters and is high for exactly one cycle per frame.
- Counters keep running (flywheel) in every FSM state, including when DE is absent.
- vsync_in held high over several lines arms the frame only once, on its rising edge.
- Reset mid-frame discards all state. A full frame start plus LOCK_FRAMES clean frames are needed again before locked asserts.

Optional Feature:
HSYNC_CHECK_EN
- Defined: adds check (e). hs_rise with next_h != ACTIVE_H_PIXELS+H_FRONT_PORCH is a violation; so is next_h == ACTIVE_H_PIXELS+H_FRONT_PORCH without hs_rise. Both are evaluated only outside UNLOCKED.
- Undefined: hsync_in is ignored, and its registers are optimised away.

Test Plan:
- Default params, compliant 1650x750 stream starting mid-frame -> locked=0 until the third frame start. locked=1 one cycle after the third frame-start de_rise. timing_error never asserts.
- Locked stream -> on the first active pixel of each frame the outputs read h_count=0, v_count=0, active_draw=1. new_frame is a single pulse at h_count=1280, v_count=719, exactly once per 1237500 cycles.
- Locked stream, one line's DE rises 1 cycle early (h_count=1648) -> timing_error one cycle, locked=0 on the same cycle, h_count restarts at 0, new_frame suppressed until relock.
- Locked stream, DE high for 1279 pixels on line 100 -> check (b) fires: timing_error pulse, locked drops.
- rst pulsed asynchronously mid-line (not clock-aligned) -> all outputs 0 before the next pixel_clk edge. Relock takes 3 frame starts again.
- HSYNC_CHECK_EN defined, hsync shifted +1 pixel on a locked stream -> timing_error. Same stimulus with the macro undefined -> no error, locked stays 1.
